// File: rtl/mbist_bg_pkg.sv
// Shared types for the MBIST data-background sequencer and its pattern decoder.
package mbist_bg_pkg;

  localparam int unsigned NUM_BG = 6;

  typedef enum logic [2:0] {
    BG_CB   = 3'd0,
    BG_ICB  = 3'd1,
    BG_HI   = 3'd2,
    BG_LO   = 3'd3,
    BG_ZERO = 3'd4,
    BG_ONE  = 3'd5
  } bg_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bg_state_t;

  typedef struct packed {
    logic     found;
    bg_code_t code;
  } bg_pick_t;

  // Lowest enabled code at or above 'from'; found=0 when none remains.
  function automatic bg_pick_t pick_enabled(input logic [NUM_BG-1:0] mask,
                                            input logic [3:0]        from);
    bg_pick_t p;
    p.found = 1'b0;
    p.code  = BG_CB;
    for (int unsigned k = NUM_BG; k > 0; k--) begin
      if (mask[k-1] && ((k - 1) >= {28'd0, from})) begin
        p.found = 1'b1;
        p.code  = bg_code_t'(3'(k - 1));
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mbist_bg_pattern.sv
// Combinational background decoder (code, address, polarity -> word); also used by the compare path.
// MBIST_BG_ADDR_CB_EN: codes 0/1 are XORed with the address LSB to form a row checkerboard.
module mbist_bg_pattern
  import mbist_bg_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  bg_code_t          code,
  input  logic              addr_lsb,
  input  logic              inv,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] pat;

  always_comb begin
    pat = '0;
    case (code)
      BG_CB:   for (int unsigned i = 0; i < DATA_W; i++) pat[i] = i[0];
      BG_ICB:  for (int unsigned i = 0; i < DATA_W; i++) pat[i] = ~i[0];
      BG_HI:   for (int unsigned i = 0; i < DATA_W; i++) pat[i] = (i >= DATA_W / 2);
      BG_LO:   for (int unsigned i = 0; i < DATA_W; i++) pat[i] = (i < DATA_W / 2);
      BG_ZERO: pat = '0;
      BG_ONE:  pat = '1;
      default: pat = '0;
    endcase
`ifdef MBIST_BG_ADDR_CB_EN
    if (code == BG_CB || code == BG_ICB)
      pat = pat ^ {DATA_W{addr_lsb}};
`endif
    word = pat ^ {DATA_W{inv}};
  end

`ifndef MBIST_BG_ADDR_CB_EN
  logic unused_addr_lsb;
  assign unused_addr_lsb = addr_lsb;
`endif

endmodule

// File: rtl/mbist_bg_seq.sv
// MBIST data-background sequencer: steps through the BG_MASK-enabled backgrounds and
// returns a registered, polarity-adjusted data word per accepted request.
module mbist_bg_seq
  import mbist_bg_pkg::*;
#(
  parameter int unsigned        DATA_W  = 8,
  parameter int unsigned        ADDR_W  = 6,
  parameter logic [NUM_BG-1:0]  BG_MASK = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bg_start,
  input  logic              bg_adv,
  input  logic              req_vld,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_inv,
  output logic              busy,
  output logic [2:0]        bg_idx,
  output logic              done,
  output logic              dout_vld,
  output logic [DATA_W-1:0] dout,
  output logic              err
);

  bg_state_t         state_q, state_d;
  bg_code_t          idx_q, idx_d;
  bg_pick_t          first_en, next_en;
  logic              acc, err_d;
  logic              busy_q, done_q, err_q, dout_vld_q;
  logic [DATA_W-1:0] dout_q, pat_word;

  assign first_en = pick_enabled(BG_MASK, 4'd0);
  assign next_en  = pick_enabled(BG_MASK, {1'b0, idx_q} + 4'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    acc     = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = req_vld | (bg_adv & ~bg_start);
        if (bg_start) begin
          if (first_en.found) begin
            state_d = RUN;
            idx_d   = first_en.code;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        acc = req_vld;
        // Restart wins over advance; an advance past the last enabled code ends the sequence.
        if (bg_start) begin
          idx_d = first_en.code;
        end else if (bg_adv) begin
          if (next_en.found) idx_d = next_en.code;
          else               state_d = DONE;
        end
      end
      DONE: begin
        err_d   = req_vld | bg_adv;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mbist_bg_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .code     (idx_q),
    .addr_lsb (req_addr[0]),
    .inv      (req_inv),
    .word     (pat_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= BG_CB;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= (state_d == RUN);
      done_q     <= (state_d == DONE);
      err_q      <= err_d;
      dout_vld_q <= acc;
      if (acc) dout_q <= pat_word;
    end
  end

  assign busy     = busy_q;
  assign bg_idx   = idx_q;
  assign done     = done_q;
  assign err      = err_q;
  assign dout_vld = dout_vld_q;
  assign dout     = dout_q;

  logic unused_addr;
  assign unused_addr = ^req_addr;

endmodule

// File: tb/tb_mbist_bg_seq.sv
// Scoreboard bench for mbist_bg_seq: default mask, mask 6'b100101 and mask 0 instances share stimulus.
module tb_mbist_bg_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bg_start = 1'b0, bg_adv = 1'b0, req_vld = 1'b0, req_inv = 1'b0;
  logic [5:0] req_addr = '0;

  logic       busy, done, dout_vld, err;
  logic [2:0] bg_idx;
  logic [7:0] dout;
  logic       m5_busy, m5_done, m5_vld, m5_err;
  logic [2:0] m5_idx;
  logic [7:0] m5_dout;
  logic       m0_busy, m0_done, m0_vld, m0_err;
  logic [2:0] m0_idx;
  logic [7:0] m0_dout;

  mbist_bg_seq #(.DATA_W(8), .ADDR_W(6), .BG_MASK(6'b111111)) u_dut (
    .clk(clk), .rst_n(rst_n), .bg_start(bg_start), .bg_adv(bg_adv), .req_vld(req_vld),
    .req_addr(req_addr), .req_inv(req_inv), .busy(busy), .bg_idx(bg_idx), .done(done),
    .dout_vld(dout_vld), .dout(dout), .err(err));

  mbist_bg_seq #(.DATA_W(8), .ADDR_W(6), .BG_MASK(6'b100101)) u_m5 (
    .clk(clk), .rst_n(rst_n), .bg_start(bg_start), .bg_adv(bg_adv), .req_vld(req_vld),
    .req_addr(req_addr), .req_inv(req_inv), .busy(m5_busy), .bg_idx(m5_idx), .done(m5_done),
    .dout_vld(m5_vld), .dout(m5_dout), .err(m5_err));

  mbist_bg_seq #(.DATA_W(8), .ADDR_W(6), .BG_MASK(6'b000000)) u_m0 (
    .clk(clk), .rst_n(rst_n), .bg_start(bg_start), .bg_adv(bg_adv), .req_vld(req_vld),
    .req_addr(req_addr), .req_inv(req_inv), .busy(m0_busy), .bg_idx(m0_idx), .done(m0_done),
    .dout_vld(m0_vld), .dout(m0_dout), .err(m0_err));

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       m0_busy_seen = 1'b0;

`ifdef MBIST_BG_ADDR_CB_EN
  localparam logic [7:0] CB0_A1 = 8'h55;
  localparam logic [7:0] CB1_A1 = 8'hAA;
`else
  localparam logic [7:0] CB0_A1 = 8'hAA;
  localparam logic [7:0] CB1_A1 = 8'h55;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m0_busy) m0_busy_seen = 1'b1;
    if (dout_vld) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dout_unexpected: got vld with dout %0h expected no vld at %0t", dout, $time);
      end else begin
        chk("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // One cycle of stimulus; returns 1 time unit after the sampling edge.
  task automatic tick(input logic st, input logic adv, input logic rv, input logic [5:0] a,
                      input logic inv, input logic push, input logic [7:0] e);
    @(negedge clk);
    bg_start = st; bg_adv = adv; req_vld = rv; req_addr = a; req_inv = inv;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();                    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00); endtask
  task automatic start();                   tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00); endtask
  task automatic adv();                     tick(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00); endtask
  task automatic req(input logic [5:0] a, input logic inv, input logic [7:0] e);
    tick(1'b0, 1'b0, 1'b1, a, inv, 1'b1, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_idx", bg_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;

    tick(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 8'h00);
    chk("idle_req_err", err, 1);
    chk("idle_req_vld", dout_vld, 0);
    idle();
    chk("idle_err_clr", err, 0);
    adv();
    chk("idle_adv_err", err, 1);
    idle();

    start();
    chk("start_busy", busy, 1);
    chk("start_idx", bg_idx, 0);
    chk("start_done", done, 0);
    chk("m5_start_idx", m5_idx, 0);
    chk("m0_done", m0_done, 1);
    chk("m0_busy", m0_busy, 0);
    idle();
    chk("m0_done_clr", m0_done, 0);

    req(6'd0, 1'b0, 8'hAA);
    chk("req_vld", dout_vld, 1);
    req(6'd0, 1'b1, 8'h55);
    req(6'd1, 1'b0, CB0_A1);
    adv();
    chk("adv1_idx", bg_idx, 1);
    chk("m5_adv1_idx", m5_idx, 2);
    tick(1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1, 8'h55);
    chk("req_adv_idx", bg_idx, 2);
    chk("m5_adv2_idx", m5_idx, 5);
    req(6'd0, 1'b1, 8'h0F);
    req(6'd0, 1'b0, 8'hF0);
    adv();
    chk("adv3_idx", bg_idx, 3);
    chk("m5_done", m5_done, 1);
    chk("m5_busy", m5_busy, 0);
    req(6'd0, 1'b0, 8'h0F);
    req(6'd1, 1'b0, 8'h0F);

    start();
    chk("restart_idx", bg_idx, 0);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    req(6'd0, 1'b0, 8'hAA);
    adv();
    chk("adv_idx1", bg_idx, 1);
    req(6'd1, 1'b0, CB1_A1);
    adv();
    chk("adv_idx2", bg_idx, 2);
    adv();
    chk("adv_idx3", bg_idx, 3);
    adv();
    chk("adv_idx4", bg_idx, 4);
    req(6'd0, 1'b0, 8'h00);
    adv();
    chk("adv_idx5", bg_idx, 5);
    req(6'd0, 1'b0, 8'hFF);
    req(6'd0, 1'b1, 8'h00);
    adv();
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    idle();
    chk("end_done_clr", done, 0);

    start();
    req(6'd0, 1'b0, 8'hAA);
    chk("pre_rst_vld", dout_vld, 1);
    chk("pre_rst_dout", dout, 8'hAA);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", dout_vld, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_idx", bg_idx, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    bg_start = 1'b0; bg_adv = 1'b0; req_vld = 1'b0;
    rst_n = 1'b1;
    idle();
    chk("post_rst_err", err, 0);
    idle();

    chk("m0_busy_never", m0_busy_seen, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
